// File: rtl/md_sched.sv
// ---------------------------------------------------------------------------
// md_sched -- issue scheduler / sequencer for the shared multiply/divide unit
//
// E-stage mult/div/mthi/mtlo operations are pushed into a small in-order
// FIFO. The head is handed to the muldiv unit only when the unit can legally
// accept it:
//   * mult/div : one-cycle md_start pulse, then the sequencer sits in ARM for
//                the unit's one-cycle busy latency and in WAIT until busy drops.
//   * mthi/mtlo: one-cycle md_hilowe pulse, only while the unit is idle and the
//                sequencer is in IDLE. A direct write must never land while a
//                result is still being computed.
//   * opcodes 6/7 are popped silently and set the sticky err flag.
// hilo_stall tells the hazard unit to hold mfhi/mflo while any operation is
// queued, in flight, or the unit reports busy.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   req_valid/req_ready push handshake from the E stage (ready = not full)
//   req_op              0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 illegal
//   req_rs, req_rt      operands captured with the operation
//   md_start            one-cycle start pulse to the muldiv unit
//   md_hilowe           one-cycle HI/LO direct write
//   md_hilo_sel         0 = HI, 1 = LO (valid with md_hilowe)
//   md_aluop            operation code (valid with md_start, else 0)
//   md_rs, md_rt        head operands during an issue cycle, else 0
//   md_busy             busy flag from the muldiv unit
//   hilo_stall          mfhi/mflo must stall
//   err                 sticky illegal-op flag, cleared only by reset
// ---------------------------------------------------------------------------
module md_sched #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [5:0]  ALU_MUL  = 6'd10,
    parameter logic [5:0]  ALU_MULU = 6'd11,
    parameter logic [5:0]  ALU_DIV  = 6'd12,
    parameter logic [5:0]  ALU_DIVU = 6'd13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_rs,
    input  logic [31:0] req_rt,
    output logic        req_ready,
    output logic        md_start,
    output logic        md_hilowe,
    output logic        md_hilo_sel,
    output logic [5:0]  md_aluop,
    output logic [31:0] md_rs,
    output logic [31:0] md_rt,
    input  logic        md_busy,
    output logic        hilo_stall,
    output logic        err
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // Sequencer states (legacy-compatible encoding).
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
    } entry_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [1:0]       state_q,  state_d;
    logic             err_q,    err_d;

    // -----------------------------------------------------------------------
    // Head decode and issue decision
    // -----------------------------------------------------------------------
    entry_t head;
    logic   queue_empty;
    logic   queue_full;
    logic   push;
    logic   issue;
    logic   head_is_mul;
    logic   head_is_mt;
    logic   head_illegal;

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        queue_empty  = (count_q == '0);
        queue_full   = (count_q == CNT_FULL);
        push         = req_valid && !queue_full;
        // Issue depends only on registered state and md_busy, never on req_*,
        // so a push into an empty queue is seen no earlier than the next cycle.
        // Gating with reset keeps the reset cycle itself pulse-free.
        issue        = !reset && (state_q == ST_IDLE) && !queue_empty && !md_busy;
        head_is_mul  = (head.op[2] == 1'b0);
        head_is_mt   = (head.op == OP_MTHI) || (head.op == OP_MTLO);
        head_illegal = (head.op[2:1] == 2'b11);
    end

    // -----------------------------------------------------------------------
    // Unit-facing outputs: zero outside issue cycles
    // -----------------------------------------------------------------------
    // NOTE: every output of a combinational block gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        md_start    = 1'b0;
        md_hilowe   = 1'b0;
        md_hilo_sel = 1'b0;
        md_aluop    = 6'd0;
        md_rs       = 32'd0;
        md_rt       = 32'd0;
        if (issue && head_is_mul) begin
            md_start = 1'b1;
            md_rs    = head.rs;
            md_rt    = head.rt;
            case (head.op)
                OP_MULT:  md_aluop = ALU_MUL;
                OP_MULTU: md_aluop = ALU_MULU;
                OP_DIV:   md_aluop = ALU_DIV;
                OP_DIVU:  md_aluop = ALU_DIVU;
                default:  md_aluop = 6'd0;
            endcase
        end else if (issue && head_is_mt) begin
            md_hilowe   = 1'b1;
            md_hilo_sel = (head.op == OP_MTLO);
            md_rs       = head.rs;
        end
    end

    assign req_ready  = !queue_full;
    assign hilo_stall = !queue_empty || (state_q != ST_IDLE) || md_busy;
    assign err        = err_q;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        state_d  = state_q;
        err_d    = err_q;

        // Pointers wrap naturally because DEPTH is a power of two.
        if (push) begin
            mem_d[wr_ptr_q] = '{op: req_op, rs: req_rs, rt: req_rt};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (issue) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, issue})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            ST_IDLE: if (issue && head_is_mul) state_d = ST_ARM;
            // Covers the unit's one-cycle delay before busy is visible.
            ST_ARM:  state_d = ST_WAIT;
            ST_WAIT: if (!md_busy) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (issue && head_illegal) begin
            err_d = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= ST_IDLE;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            err_q    <= err_d;
        end
    end

    // NOTE: queue storage is deliberately not reset; an entry is only read
    // once count says it was written, and the outputs are zeroed otherwise.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_md_sched.sv
// ---------------------------------------------------------------------------
// tb_md_sched -- self-checking bench for md_sched
//
// A small behavioural muldiv unit drives md_busy and keeps HI/LO. A reference
// model (FIFO of pending operations plus the issue-timing rules) predicts every
// scheduler output each cycle; directed scenarios are followed by a random run.
// ---------------------------------------------------------------------------
module tb_md_sched;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_rs;
    logic [31:0] req_rt;
    logic        req_ready;
    logic        md_start;
    logic        md_hilowe;
    logic        md_hilo_sel;
    logic [5:0]  md_aluop;
    logic [31:0] md_rs;
    logic [31:0] md_rt;
    logic        md_busy;
    logic        hilo_stall;
    logic        err;

    always #5 clk = ~clk;

    md_sched #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_op      (req_op),
        .req_rs      (req_rs),
        .req_rt      (req_rt),
        .req_ready   (req_ready),
        .md_start    (md_start),
        .md_hilowe   (md_hilowe),
        .md_hilo_sel (md_hilo_sel),
        .md_aluop    (md_aluop),
        .md_rs       (md_rs),
        .md_rt       (md_rt),
        .md_busy     (md_busy),
        .hilo_stall  (hilo_stall),
        .err         (err)
    );

    // -----------------------------------------------------------------------
    // Behavioural muldiv unit: busy from the cycle after start for lat cycles
    // -----------------------------------------------------------------------
    int          busy_cnt;
    int          lat_force;
    logic [31:0] hi;
    logic [31:0] lo;

    assign md_busy = (busy_cnt != 0);

    function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] x;
        logic signed [63:0] y;
        x = {{32{a[31]}}, a};
        y = {{32{b[31]}}, b};
        return x * y;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            busy_cnt <= 0;
            hi       <= 32'd0;
            lo       <= 32'd0;
        end else begin
            if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
            if (md_start) begin
                busy_cnt <= (lat_force != 0) ? lat_force : int'($urandom_range(1, 6));
                case (md_aluop)
                    6'd10: {hi, lo} <= smul(md_rs, md_rt);
                    6'd11: {hi, lo} <= {32'd0, md_rs} * {32'd0, md_rt};
                    6'd12: if (md_rt != 0) begin
                               lo <= $signed(md_rs) / $signed(md_rt);
                               hi <= $signed(md_rs) % $signed(md_rt);
                           end
                    6'd13: if (md_rt != 0) begin
                               lo <= md_rs / md_rt;
                               hi <= md_rs % md_rt;
                           end
                    default: ;
                endcase
            end else if (md_hilowe) begin
                if (md_hilo_sel) lo <= md_rs;
                else             hi <= md_rs;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Reference model and checking
    // -----------------------------------------------------------------------
    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
    } op_t;

    op_t mq[$];       // operations accepted but not yet issued, program order
    bit  m_blocked;   // a mult/div was started and has not been released yet
    int  m_age;       // cycles since that start
    bit  m_err;
    bit  ready_low_seen;
    int  n_checks;
    int  n_pass;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock cycle: drive inputs, predict and compare outputs mid-cycle,
    // then advance the model with what happened at the edge.
    task automatic step(input bit v, input logic [2:0] op,
                        input logic [31:0] rs, input logic [31:0] rt);
        bit          can;
        bit          busy_now;
        bit          push_ok;
        bit          e_start;
        bit          e_hwe;
        bit          e_sel;
        logic [5:0]  e_alu;
        logic [31:0] e_rs;
        logic [31:0] e_rt;
        op_t         h;
        req_valid = v;
        req_op    = op;
        req_rs    = rs;
        req_rt    = rt;
        @(negedge clk);
        busy_now = md_busy;
        push_ok  = v && (mq.size() != DEPTH);
        can      = !reset && !m_blocked && (mq.size() != 0) && !busy_now;
        e_start = 0; e_hwe = 0; e_sel = 0; e_alu = 6'd0; e_rs = 32'd0; e_rt = 32'd0;
        h = '{op: 3'd0, rs: 32'd0, rt: 32'd0};
        if (can) begin
            h = mq[0];
            case (h.op)
                3'd0: begin e_start = 1; e_alu = 6'd10; end
                3'd1: begin e_start = 1; e_alu = 6'd11; end
                3'd2: begin e_start = 1; e_alu = 6'd12; end
                3'd3: begin e_start = 1; e_alu = 6'd13; end
                3'd4: e_hwe = 1;
                3'd5: begin e_hwe = 1; e_sel = 1; end
                default: ;
            endcase
            if (e_start) begin e_rs = h.rs; e_rt = h.rt; end
            if (e_hwe)   e_rs = h.rs;
        end
        if (!reset) begin
            check("md_start",    md_start,    e_start);
            check("md_hilowe",   md_hilowe,   e_hwe);
            check("md_hilo_sel", md_hilo_sel, e_sel);
            check("md_aluop",    md_aluop,    e_alu);
            check("md_rs",       md_rs,       e_rs);
            check("md_rt",       md_rt,       e_rt);
            check("req_ready",   req_ready,   mq.size() != DEPTH);
            check("hilo_stall",  hilo_stall,  (mq.size() != 0) || m_blocked || busy_now);
            check("err",         err,         m_err);
            if (!req_ready) ready_low_seen = 1;
        end
        @(posedge clk);
        if (reset) begin
            mq.delete();
            m_blocked = 0;
            m_age     = 0;
            m_err     = 0;
        end else begin
            // Released once busy=0 is seen at least two cycles after the start.
            if (m_blocked) begin
                if (m_age >= 2 && !busy_now) m_blocked = 0;
                else m_age++;
            end
            if (can) begin
                if (h.op == 3'd6 || h.op == 3'd7) m_err = 1;
                if (e_start) begin m_blocked = 1; m_age = 1; end
                void'(mq.pop_front());
            end
            if (push_ok) mq.push_back('{op: op, rs: rs, rt: rt});
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 3'd0, 32'd0, 32'd0);
    endtask

    // Hold req_valid until the operation is accepted.
    task automatic push_hold(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
        int  n;
        bit  accepted;
        n = 0;
        accepted = 0;
        while (!accepted && n < 100) begin
            accepted = (mq.size() != DEPTH);
            step(1, op, rs, rt);
            n++;
        end
        check("push_timeout", accepted, 1'b1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((mq.size() != 0 || m_blocked || md_busy) && n < 200) begin
            step(0, 3'd0, 32'd0, 32'd0);
            n++;
        end
        check("drain_timeout", n < 200, 1'b1);
    endtask

    initial begin
        reset = 1; req_valid = 0; req_op = 3'd0; req_rs = 32'd0; req_rt = 32'd0;
        lat_force = 0; n_checks = 0; n_pass = 0;
        m_blocked = 0; m_age = 0; m_err = 0; ready_low_seen = 0;

        // Reset held two cycles, then idle outputs.
        idle(2);
        reset = 0;
        idle(2);

        // Single signed MULT: 3 * -2.
        lat_force = 5;
        step(1, 3'd0, 32'd3, 32'hFFFF_FFFE);
        drain();
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);

        // Back-to-back DIV / MTLO / MULTU with a full queue in between.
        lat_force = 4;
        ready_low_seen = 0;
        push_hold(3'd2, 32'd7, 32'd2);
        push_hold(3'd5, 32'h55, 32'd0);
        push_hold(3'd1, 32'd2, 32'd3);
        drain();
        check("b2b_full_seen", ready_low_seen, 1'b1);
        check("b2b_hi", hi, 32'd0);
        check("b2b_lo", lo, 32'd6);

        // Illegal opcode: silent pop, sticky err.
        step(1, 3'd7, 32'hDEAD, 32'hBEEF);
        drain();
        check("illegal_err", err, 1'b1);
        push_hold(3'd0, 32'd5, 32'd6);
        drain();
        check("err_sticky", err, 1'b1);
        check("post_illegal_lo", lo, 32'd30);

        // Reset while in WAIT with two entries queued.
        lat_force = 8;
        step(1, 3'd0, 32'd9, 32'd9);
        step(1, 3'd4, 32'h11, 32'd0);
        step(1, 3'd1, 32'd4, 32'd4);
        idle(1);
        check("pre_rst_full", req_ready, 1'b0);
        reset = 1;
        idle(1);
        reset = 0;
        idle(12);
        check("rst_wait_err", err, 1'b0);

        // Push while the single queued entry pops.
        lat_force = 3;
        step(1, 3'd0, 32'd4, 32'd5);
        step(1, 3'd3, 32'd100, 32'd7);
        drain();
        check("pushpop_hi", hi, 32'd2);
        check("pushpop_lo", lo, 32'd14);

        // Random traffic with random latency and occasional reset.
        lat_force = 0;
        for (int i = 0; i < 400; i++) begin
            bit          v;
            logic [2:0]  op;
            v  = ($urandom_range(0, 2) != 0);
            op = ($urandom_range(0, 15) == 0) ? 3'(6 + $urandom_range(0, 1))
                                              : 3'($urandom_range(0, 5));
            reset = ($urandom_range(0, 99) == 0);
            step(v, op, $urandom, $urandom);
        end
        reset = 0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
